clk_div_gen: RTL



---
 rtl/clk_div_pkg.sv | 33 +++
 rtl/clk_div_ch.sv | 67 ++++++
 rtl/clk_div_gen.sv | 81 ++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_gen fabric clock generator:
// sequencing states, per-channel reset defaults and request validation.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ALIGN   = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
    logic [31:0] phase;
  } ch_cfg_t;

  // Channel idx powers up at sys_clk/(2<<idx), 50% duty, no phase offset.
  function automatic ch_cfg_t default_cfg(input int unsigned idx);
    default_cfg.div   = 32'd2 << idx;
    default_cfg.high  = 32'd1 << idx;
    default_cfg.phase = 32'd0;
  endfunction

  function automatic logic cfg_is_valid(input logic [31:0] ch,
                                        input logic [31:0] num_ch,
                                        input logic [31:0] div,
                                        input logic [31:0] high,
                                        input logic [31:0] phase);
    return (ch < num_ch) && (div >= 32'd2) && (high >= 32'd1) &&
           (high <= div - 32'd1) && (phase <= div - 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: holds its divide/high/phase, runs the period
// counter and produces registered clk_out and its rising-edge strobe.
module clk_div_ch #(
  parameter int          CNT_W  = 16,
  parameter int unsigned CH_IDX = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             realign,
  input  logic             load,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             clk_out,
  output logic             rise_stb
);
  import clk_div_pkg::*;

  localparam ch_cfg_t          DEF_CFG   = default_cfg(CH_IDX);
  localparam logic [CNT_W-1:0] DEF_DIV   = DEF_CFG.div[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DEF_HIGH  = DEF_CFG.high[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DEF_PHASE = DEF_CFG.phase[CNT_W-1:0];

  logic [CNT_W-1:0] div_q, high_q, phase_q;
  logic [CNT_W-1:0] cnt_p0;
  logic             clk_p0, rise_p0;
  logic [CNT_W-1:0] preload, cnt_inc;

  // Starting the count at div-phase puts the first wrap to 0 (rising edge)
  // exactly phase cycles after the alignment edge.
  assign preload = (phase_q == '0) ? '0 : div_q - phase_q;
  assign cnt_inc = (cnt_p0 == div_q - CNT_W'(1)) ? '0 : cnt_p0 + CNT_W'(1);

  // Stage p0: counter, level and strobe all registered together
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div_q   <= DEF_DIV;
      high_q  <= DEF_HIGH;
      phase_q <= DEF_PHASE;
      cnt_p0  <= '0;
      clk_p0  <= 1'b0;
      rise_p0 <= 1'b0;
    end else if (realign) begin
      if (wr_en) begin
        div_q   <= wr_div;
        high_q  <= wr_high;
        phase_q <= wr_phase;
      end
      cnt_p0  <= '0;
      clk_p0  <= 1'b0;
      rise_p0 <= 1'b0;
    end else if (load) begin
      cnt_p0  <= preload;
      clk_p0  <= (preload < high_q);
      rise_p0 <= (preload < high_q);
    end else begin
      cnt_p0  <= cnt_inc;
      clk_p0  <= (cnt_inc < high_q);
      rise_p0 <= (cnt_inc < high_q) & ~clk_p0;
    end
  end

  assign clk_out  = clk_p0;
  assign rise_stb = rise_p0;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel fabric clock generator: ALIGN/LOCKING/LOCKED sequencing,
// lock counter and the config handshake around NUM_CH divider channels.
module clk_div_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic              locked
);
  import clk_div_pkg::*;

  localparam int             LCK_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYCLES - 1);

  state_t           state_q, state_nxt;
  logic [LCK_W-1:0] lock_cnt_q;
  logic             cfg_err_q;
  logic             xfer, cfg_ok, accept;

  assign xfer   = cfg_valid & cfg_ready;
  assign cfg_ok = cfg_is_valid(32'(cfg_ch), 32'(NUM_CH), 32'(cfg_div),
                               32'(cfg_high), 32'(cfg_phase));
  assign accept = xfer & cfg_ok;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ALIGN:   state_nxt = LOCKING;
      LOCKING: if (lock_cnt_q == LCK_LAST) state_nxt = LOCKED;
      LOCKED:  if (accept) state_nxt = ALIGN;
      default: state_nxt = ALIGN;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ALIGN;
      lock_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      lock_cnt_q <= (state_q == LOCKING) ? lock_cnt_q + LCK_W'(1) : '0;
      cfg_err_q  <= xfer & ~cfg_ok;
    end
  end

  assign cfg_ready = (state_q == LOCKED);
  assign locked    = (state_q == LOCKED);
  assign cfg_err   = cfg_err_q;

  // Every channel re-aligns on any accepted write so relative phases hold.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W  (CNT_W),
      .CH_IDX (i)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .realign   (accept),
      .load      (state_q == ALIGN),
      .wr_en     (accept && (cfg_ch == 4'(i))),
      .wr_div    (cfg_div),
      .wr_high   (cfg_high),
      .wr_phase  (cfg_phase),
      .clk_out   (clk_out[i]),
      .rise_stb  (rise_stb[i])
    );
  end

endmodule
